spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI responder (peripheral side): the far end of the team's SPI master core, used for SPI loopback benches and for FPGA targets that are driven by an external SPI host.
- Oversamples SCLK/SS_N/MOSI in the system clock domain, shifts DW-bit words, drives MISO.
- Exposes a valid/ready TX byte buffer and a one-cycle RX strobe to local logic.
- Supports all four CPOL/CPHA modes and multi-word frames under one SS_N assertion.

Parameters:
- DW, 8, word width in bits (>= 2).
- SYNC_STAGES, 2, synchroniser depth for sclk/ss_n/mosi (>= 2).

Ports:
- clk  in  1  system clock; must be >= 4x the SCLK frequency.
- rst_n  in  1  asynchronous, active-low reset.
- cpol  in  1  clock idle level; sampled at frame start.
- cpha  in  1  clock phase; sampled at frame start.
- tx_data  in  DW  next word to shift out.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX buffer empty; a word is accepted when tx_valid and tx_ready are both high.
- rx_data  out  DW  last received word; held until the next word completes.
- rx_valid  out  1  one-cycle strobe when rx_data updates.
- underrun  out  1  one-cycle strobe when a word was loaded with the TX buffer empty.
- frame_abort  out  1  one-cycle strobe when ss_n deasserts mid-word.
- busy  out  1  high while a frame is active.
- spi_sclk  in  1  SPI clock from the master.
- spi_ss_n  in  1  slave select, active-low.
- spi_mosi  in  1  data from the master.
- spi_miso  out  1  data to the master.
- spi_miso_oe  out  1  tri-state enable; high only while selected.

Behaviour:
- Reset values:
  - All outputs are 0, except tx_ready=1.
  - Synchronisers preload ss_n=1 and sclk=0.
  - State is IDLE; TX buffer is empty.
- Synchronisation:
  - sclk, ss_n and mosi each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised sclk against a one-cycle-delayed copy.
  - Leading edge = transition away from the latched cpol; trailing edge = transition back to it.
- State machine: IDLE, LOAD, ACTIVE.
  - IDLE: on synchronised ss_n falling, latch cpol/cpha, go to LOAD.
  - LOAD (one cycle):
    - Shift register <= TX buffer if full (buffer then emptied, tx_ready rises next cycle).
    - Otherwise shift register <= 0 and underrun pulses.
    - bit_cnt <= 0. Go to ACTIVE.
  - ACTIVE, sampling and shifting:
    - cpha=0: sample mosi on the leading edge, shift on the trailing edge.
    - cpha=1: shift on the leading edge, sample on the trailing edge; the first leading edge does not shift.
    - Each sample increments bit_cnt.
  - ACTIVE, word completion:
    - When bit_cnt reaches DW, the cycle after the DW-th sample: rx_data <= assembled word, rx_valid=1.
    - bit_cnt <= 0 and the next word is loaded into the shift register exactly as in LOAD.
    - underrun pulses in that same cycle if the TX buffer is empty.
  - ACTIVE, ss_n high:
    - If bit_cnt != 0, frame_abort pulses and the partial word is discarded (no rx_valid).
    - Go to IDLE.
    - Any word already loaded into the shift register is lost; the buffered word stays.
- Output bit order: spi_miso = shift-register MSB (MSB first). spi_miso_oe = ~ss_n_sync. busy = state != IDLE.
- TX buffer:
  - Single entry; tx_ready = ~full.
  - Acceptance and consumption in the same cycle are impossible, because consumption requires full=1.
  - A tx_valid held with tx_ready low is ignored until accepted.
- Simultaneous ss_n rise and the DW-th sample: the sample completes the word, rx_valid pulses, then IDLE with no abort.
- cpol/cpha changes during a frame have no effect until the next ss_n fall.
- rst_n asserted mid-frame: immediate return to the reset values; spi_miso_oe=0 asynchronously.

Optional Feature:
- Macro: SPI_SLAVE_LSB_FIRST_EN.
- Defined: both TX and RX are LSB-first. spi_miso = shift-register LSB, shifting is right, received bits enter at the MSB, and rx_data is the word in natural order.
- Undefined: MSB-first only, with no extra logic.

Decomposition:
- Shared package spi_pkg holds:
  - typedef enum logic [1:0] spi_slv_state_t {IDLE, LOAD, ACTIVE};
  - localparam SPI_DW_DEFAULT = 8;
  - a mode typedef struct packed {cpol, cpha}, shared with the master core.
- One sub-module, spi_sync_edge: SYNC_STAGES-deep synchroniser plus rise/fall detect, instanced once per input (sclk, ss_n, mosi; edge outputs unused for mosi).

Test Plan:
- Mode 0, clk=8x sclk: tx_data=0xA5 preloaded; master sends 0x3C → master receives 0xA5; rx_data=0x3C with exactly one rx_valid pulse; tx_ready returns high.
- Modes 1/2/3 sweep: master sends 0x81, slave sends 0x7E → both ends correct in every mode; spi_miso_oe tracks ss_n.
- 3-word frame, ss_n held low: slave buffer refilled after each tx_ready, words 0x11,0x22,0x33 → three rx_valid pulses; master reads 0x11,0x22,0x33; no underrun.
- TX buffer empty at frame start, master sends 0xFF → slave shifts out 0x00; underrun pulses once; rx_data=0xFF.
- ss_n deasserted after 5 bits → frame_abort=1 for one cycle; no rx_valid; busy=0 within SYNC_STAGES+2 cycles; next full frame still correct.
- rst_n pulsed low mid-word → all outputs at reset values; spi_miso_oe=0 immediately; the following frame with tx_data=0x5A completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: slave FSM states, default word width and the
// CPOL/CPHA mode record used by both the master and the slave cores.
package spi_pkg;

    localparam int SPI_DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } spi_slv_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall
// detection of the synchronised level against a one-cycle-delayed copy.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   q_d_r;

    // synchroniser chain plus delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{RESET_VAL}};
            q_d_r  <= RESET_VAL;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
            q_d_r  <= sync_r[SYNC_STAGES-1];
        end
    end

    assign q    = sync_r[SYNC_STAGES-1];
    assign rise = sync_r[SYNC_STAGES-1] & ~q_d_r;
    assign fall = ~sync_r[SYNC_STAGES-1] & q_d_r;

endmodule

// File: rtl/spi_slave.sv
// SPI peripheral: oversampled SCLK/SS_N/MOSI, DW-bit words, single-entry TX
// buffer, all four CPOL/CPHA modes. Define SPI_SLAVE_LSB_FIRST_EN for LSB-first.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DW          = SPI_DW_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpol,
    input  logic          cpha,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          underrun,
    output logic          frame_abort,
    output logic          busy,
    input  logic          spi_sclk,
    input  logic          spi_ss_n,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe
);

    localparam int              CW        = $clog2(DW + 1);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(DW);
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    spi_slv_state_t state_r, state_nxt_s;
    spi_mode_t      mode_r;

    logic [DW-1:0] tx_buf_r, tx_shift_r, rx_shift_r, rx_data_r;
    logic [DW-1:0] tx_shifted_s, rx_next_s;
    logic [CW-1:0] bit_cnt_r;
    logic          tx_full_r, rx_valid_r, underrun_r, frame_abort_r;

    logic sclk_lvl_unused_s, sclk_rise_s, sclk_fall_s;
    logic ss_n_s, ss_rise_unused_s, ss_fall_s;
    logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;
    logic lead_s, trail_s, sample_edge_s, shift_edge_s;
    logic latch_mode_s, load_s, complete_s, sample_s, shift_s, abort_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(spi_sclk),
        .q(sclk_lvl_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss_n (
        .clk(clk), .rst_n(rst_n), .d(spi_ss_n),
        .q(ss_n_s), .rise(ss_rise_unused_s), .fall(ss_fall_s)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(spi_mosi),
        .q(mosi_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
    );

    // Leading edge leaves the latched idle level, trailing edge returns to it.
    assign lead_s        = mode_r.cpol ? sclk_fall_s : sclk_rise_s;
    assign trail_s       = mode_r.cpol ? sclk_rise_s : sclk_fall_s;
    assign sample_edge_s = mode_r.cpha ? trail_s : lead_s;
    assign shift_edge_s  = mode_r.cpha ? lead_s : trail_s;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign tx_shifted_s = {1'b0, tx_shift_r[DW-1:1]};
    assign rx_next_s    = {mosi_s, rx_shift_r[DW-1:1]};
    assign spi_miso     = tx_shift_r[0];
`else
    assign tx_shifted_s = {tx_shift_r[DW-2:0], 1'b0};
    assign rx_next_s    = {rx_shift_r[DW-2:0], mosi_s};
    assign spi_miso     = tx_shift_r[DW-1];
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (ss_fall_s) state_nxt_s = LOAD;
                else           state_nxt_s = IDLE;
            end
            LOAD: state_nxt_s = ACTIVE;
            ACTIVE: begin
                // A pending sample is allowed to finish before ss_n is honoured.
                if (bit_cnt_r == CNT_FULL) begin
                    if (ss_n_s) state_nxt_s = IDLE;
                    else        state_nxt_s = ACTIVE;
                end else if (sample_edge_s) begin
                    state_nxt_s = ACTIVE;
                end else if (ss_n_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode into datapath control strobes
    always_comb begin
        latch_mode_s = 1'b0;
        load_s       = 1'b0;
        complete_s   = 1'b0;
        sample_s     = 1'b0;
        shift_s      = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (ss_fall_s) latch_mode_s = 1'b1;
                else           latch_mode_s = 1'b0;
            end
            LOAD: load_s = 1'b1;
            ACTIVE: begin
                if (bit_cnt_r == CNT_FULL) begin
                    complete_s = 1'b1;
                    load_s     = ~ss_n_s;
                end else if (sample_edge_s) begin
                    sample_s = 1'b1;
                end else if (ss_n_s) begin
                    abort_s = (bit_cnt_r != CNT_ZERO);
                end else begin
                    // bit_cnt of zero marks a freshly loaded word whose MSB must stay put
                    shift_s = shift_edge_s && (bit_cnt_r != CNT_ZERO);
                end
            end
            default: latch_mode_s = 1'b0;
        endcase
    end

    // single-entry TX holding buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf_r  <= {DW{1'b0}};
            tx_full_r <= 1'b0;
        end else if (tx_valid && !tx_full_r) begin
            tx_buf_r  <= tx_data;
            tx_full_r <= 1'b1;
        end else if (load_s && tx_full_r) begin
            tx_full_r <= 1'b0;
        end
    end

    // shift registers, bit counter, mode latch and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r        <= '{cpol: 1'b0, cpha: 1'b0};
            tx_shift_r    <= {DW{1'b0}};
            rx_shift_r    <= {DW{1'b0}};
            rx_data_r     <= {DW{1'b0}};
            bit_cnt_r     <= CNT_ZERO;
            rx_valid_r    <= 1'b0;
            underrun_r    <= 1'b0;
            frame_abort_r <= 1'b0;
        end else begin
            rx_valid_r    <= complete_s;
            underrun_r    <= load_s & ~tx_full_r;
            frame_abort_r <= abort_s;
            if (latch_mode_s) begin
                mode_r.cpol <= cpol;
                mode_r.cpha <= cpha;
            end
            if (load_s) begin
                tx_shift_r <= tx_full_r ? tx_buf_r : {DW{1'b0}};
            end else if (shift_s) begin
                tx_shift_r <= tx_shifted_s;
            end
            if (load_s || complete_s) begin
                bit_cnt_r <= CNT_ZERO;
            end else if (sample_s) begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end
            if (sample_s) begin
                rx_shift_r <= rx_next_s;
            end
            if (complete_s) begin
                rx_data_r <= rx_shift_r;
            end
        end
    end

    assign tx_ready    = ~tx_full_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign underrun    = underrun_r;
    assign frame_abort = frame_abort_r;
    assign busy        = (state_r != IDLE);
    assign spi_miso_oe = ~ss_n_s;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master at clk = 8x sclk
// with hand-computed expected words for every mode and corner case.
module tb_spi_slave;

    localparam int DW          = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 40;

    logic          clk, rst_n, cpol, cpha;
    logic [DW-1:0] tx_data, rx_data;
    logic          tx_valid, tx_ready, rx_valid, underrun, frame_abort, busy;
    logic          spi_sclk, spi_ss_n, spi_mosi, spi_miso, spi_miso_oe;

    int checks   = 0;
    int failures = 0;
    int rx_cnt   = 0;
    int ur_cnt   = 0;
    int ab_cnt   = 0;
    logic [7:0] rx_log [0:63];

    spi_slave #(.DW(DW), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun),
        .frame_abort(frame_abort), .busy(busy),
        .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters for the strobed outputs
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt[5:0]] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (underrun)    ur_cnt = ur_cnt + 1;
        if (frame_abort) ab_cnt = ab_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] w);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!tx_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_tx_wait got=%b want=1", tx_ready);
        end
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic frame_begin(input logic p, input logic h);
        cpol     = p;
        cpha     = h;
        spi_sclk = p;
        #80;
        spi_ss_n = 1'b0;
        #80;
    endtask

    task automatic frame_end();
        #HALF;
        spi_ss_n = 1'b1;
        #80;
    endtask

    // master side of one word, MSB first; nbits < 8 stops mid-word
    task automatic spi_word(input logic p, input logic h, input logic [7:0] mo,
                            input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!h) begin
                spi_mosi = mo[i];
                #HALF;
                spi_sclk = ~p;
                mi[i] = spi_miso;
                #HALF;
                spi_sclk = p;
            end else begin
                spi_sclk = ~p;
                spi_mosi = mo[i];
                #HALF;
                spi_sclk = p;
                mi[i] = spi_miso;
                #HALF;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clks(3);
        checks++; if (tx_ready !== 1'b1)    begin failures++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
        checks++; if (rx_data !== 8'h00)    begin failures++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
        checks++; if (rx_valid !== 1'b0)    begin failures++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        checks++; if (underrun !== 1'b0)    begin failures++; $display("FAIL reset_underrun got=%b want=0", underrun); end
        checks++; if (frame_abort !== 1'b0) begin failures++; $display("FAIL reset_abort got=%b want=0", frame_abort); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (spi_miso !== 1'b0)    begin failures++; $display("FAIL reset_miso got=%b want=0", spi_miso); end
        checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b want=0", spi_miso_oe); end
        rst_n = 1'b1;
        wait_clks(3);
    endtask

    task automatic test_mode0();
        int rx0;
        logic [7:0] got;
        rx0 = rx_cnt;
        load_tx(8'hA5);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL m0_tx_full got=%b want=0", tx_ready); end
        frame_begin(1'b0, 1'b0);
        spi_word(1'b0, 1'b0, 8'h3C, 8, got);
        frame_end();
        wait_clks(4);
        checks++; if (got !== 8'hA5)        begin failures++; $display("FAIL m0_miso got=%h want=a5", got); end
        checks++; if (rx_data !== 8'h3C)    begin failures++; $display("FAIL m0_rx_data got=%h want=3c", rx_data); end
        checks++; if (rx_cnt - rx0 != 1)    begin failures++; $display("FAIL m0_rx_pulses got=%0d want=1", rx_cnt - rx0); end
        checks++; if (tx_ready !== 1'b1)    begin failures++; $display("FAIL m0_tx_ready got=%b want=1", tx_ready); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL m0_busy got=%b want=0", busy); end
    endtask

    task automatic test_modes();
        int rx0;
        logic p, h;
        logic [7:0] got;
        for (int m = 1; m < 4; m++) begin
            p = m[1];
            h = m[0];
            rx0 = rx_cnt;
            load_tx(8'h7E);
            frame_begin(p, h);
            checks++; if (spi_miso_oe !== 1'b1) begin failures++; $display("FAIL modes_oe_sel m=%0d got=%b want=1", m, spi_miso_oe); end
            spi_word(p, h, 8'h81, 8, got);
            frame_end();
            wait_clks(2);
            checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL modes_oe_desel m=%0d got=%b want=0", m, spi_miso_oe); end
            checks++; if (got !== 8'h7E)        begin failures++; $display("FAIL modes_miso m=%0d got=%h want=7e", m, got); end
            checks++; if (rx_data !== 8'h81)    begin failures++; $display("FAIL modes_rx_data m=%0d got=%h want=81", m, rx_data); end
            checks++; if (rx_cnt - rx0 != 1)    begin failures++; $display("FAIL modes_rx_pulses m=%0d got=%0d want=1", m, rx_cnt - rx0); end
        end
    endtask

    task automatic test_back_to_back();
        int rx0, ur0, guard;
        logic [7:0] mo_w [0:2];
        logic [7:0] exp_w [0:2];
        logic [7:0] refill [0:2];
        logic [7:0] got_w [0:2];
        mo_w[0] = 8'hC1; mo_w[1] = 8'hC2; mo_w[2] = 8'hC3;
        exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;
        refill[0] = 8'h22; refill[1] = 8'h33; refill[2] = 8'h44;
        rx0 = rx_cnt;
        ur0 = ur_cnt;
        load_tx(8'h11);
        fork
            begin
                frame_begin(1'b0, 1'b0);
                for (int k = 0; k < 3; k++) spi_word(1'b0, 1'b0, mo_w[k], 8, got_w[k]);
                frame_end();
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    guard = 0;
                    @(negedge clk);
                    while (!tx_ready && guard < 300) begin
                        @(negedge clk);
                        guard++;
                    end
                    checks++;
                    if (tx_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL b2b_refill_wait k=%0d got=%b want=1", k, tx_ready);
                    end
                    tx_data  = refill[k];
                    tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
            end
        join
        wait_clks(4);
        for (int k = 0; k < 3; k++) begin
            checks++; if (got_w[k] !== exp_w[k])      begin failures++; $display("FAIL b2b_miso k=%0d got=%h want=%h", k, got_w[k], exp_w[k]); end
            checks++; if (rx_log[rx0 + k] !== mo_w[k]) begin failures++; $display("FAIL b2b_rx k=%0d got=%h want=%h", k, rx_log[rx0 + k], mo_w[k]); end
        end
        checks++; if (rx_cnt - rx0 != 3) begin failures++; $display("FAIL b2b_rx_pulses got=%0d want=3", rx_cnt - rx0); end
        checks++; if (ur_cnt - ur0 != 0) begin failures++; $display("FAIL b2b_underrun got=%0d want=0", ur_cnt - ur0); end
    endtask

    task automatic test_underrun();
        int rx0, ur0;
        logic [7:0] got;
        rx0 = rx_cnt;
        ur0 = ur_cnt;
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL ur_empty got=%b want=1", tx_ready); end
        frame_begin(1'b0, 1'b0);
        // refill after LOAD so only the frame-start load finds the buffer empty
        load_tx(8'h55);
        spi_word(1'b0, 1'b0, 8'hFF, 8, got);
        frame_end();
        wait_clks(4);
        checks++; if (got !== 8'h00)     begin failures++; $display("FAIL ur_miso got=%h want=00", got); end
        checks++; if (ur_cnt - ur0 != 1) begin failures++; $display("FAIL ur_pulses got=%0d want=1", ur_cnt - ur0); end
        checks++; if (rx_data !== 8'hFF) begin failures++; $display("FAIL ur_rx_data got=%h want=ff", rx_data); end
        checks++; if (rx_cnt - rx0 != 1) begin failures++; $display("FAIL ur_rx_pulses got=%0d want=1", rx_cnt - rx0); end
    endtask

    task automatic test_abort();
        int rx0, ab0, guard;
        logic [7:0] got;
        rx0 = rx_cnt;
        ab0 = ab_cnt;
        load_tx(8'h96);
        frame_begin(1'b0, 1'b0);
        spi_word(1'b0, 1'b0, 8'h5A, 5, got);
        #HALF;
        spi_ss_n = 1'b1;
        guard = 0;
        while (busy && guard < SYNC_STAGES + 2) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
        wait_clks(4);
        checks++; if (ab_cnt - ab0 != 1) begin failures++; $display("FAIL abort_pulses got=%0d want=1", ab_cnt - ab0); end
        checks++; if (rx_cnt - rx0 != 0) begin failures++; $display("FAIL abort_rx_pulses got=%0d want=0", rx_cnt - rx0); end
        checks++; if (got !== 8'h90)     begin failures++; $display("FAIL abort_partial_miso got=%h want=90", got); end
        load_tx(8'h69);
        frame_begin(1'b0, 1'b0);
        spi_word(1'b0, 1'b0, 8'hD2, 8, got);
        frame_end();
        wait_clks(4);
        checks++; if (got !== 8'h69)     begin failures++; $display("FAIL abort_next_miso got=%h want=69", got); end
        checks++; if (rx_data !== 8'hD2) begin failures++; $display("FAIL abort_next_rx got=%h want=d2", rx_data); end
        checks++; if (rx_cnt - rx0 != 1) begin failures++; $display("FAIL abort_next_pulses got=%0d want=1", rx_cnt - rx0); end
    endtask

    task automatic test_reset_mid_frame();
        int rx0;
        logic [7:0] got;
        load_tx(8'hFF);
        frame_begin(1'b0, 1'b0);
        load_tx(8'h0F);
        spi_word(1'b0, 1'b0, 8'hA0, 3, got);
        wait_clks(4);
        checks++; if (spi_miso !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_miso got=%b want=1", spi_miso); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_pre_ready got=%b want=0", tx_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL rst_mid_oe got=%b want=0", spi_miso_oe); end
        checks++; if (spi_miso !== 1'b0)    begin failures++; $display("FAIL rst_mid_miso got=%b want=0", spi_miso); end
        checks++; if (tx_ready !== 1'b1)    begin failures++; $display("FAIL rst_mid_tx_ready got=%b want=1", tx_ready); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        checks++; if (rx_data !== 8'h00)    begin failures++; $display("FAIL rst_mid_rx_data got=%h want=00", rx_data); end
        spi_ss_n = 1'b1;
        spi_sclk = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3);
        rx0 = rx_cnt;
        load_tx(8'h5A);
        frame_begin(1'b0, 1'b0);
        spi_word(1'b0, 1'b0, 8'hE7, 8, got);
        frame_end();
        wait_clks(4);
        checks++; if (got !== 8'h5A)     begin failures++; $display("FAIL rst_after_miso got=%h want=5a", got); end
        checks++; if (rx_data !== 8'hE7) begin failures++; $display("FAIL rst_after_rx got=%h want=e7", rx_data); end
        checks++; if (rx_cnt - rx0 != 1) begin failures++; $display("FAIL rst_after_pulses got=%0d want=1", rx_cnt - rx0); end
    endtask

    initial begin
        rst_n    = 1'b0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        spi_sclk = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        @(negedge clk);
        test_reset();
        test_mode0();
        test_modes();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
